// File: rtl/i2c_write_engine_pkg.sv
// Shared definitions for the I2C write engine: FSM states, quarter indices and transaction sizing.
package i2c_write_engine_pkg;

    localparam int NUM_BYTES = 3;
    localparam int DATA_W    = 8 * NUM_BYTES;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_ACK   = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quarter_t;

endpackage

// File: rtl/i2c_quarter_tick.sv
// SCL quarter-period divider: tick is high on the last cycle of each CLK_DIV-cycle quarter.
module i2c_quarter_tick #(
    parameter int CLK_DIV = 125
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/i2c_write_engine.sv
// Bit-level I2C master: one START, three bytes with ACK slots, one STOP per accepted request.
// Handshake: start is sampled only in IDLE; the accept edge clears done/ack, done then rises as a level when the write ends and holds until the next accept.
module i2c_write_engine
    import i2c_write_engine_pkg::*;
#(
    parameter int CLK_DIV = 125
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] i2c_data,
    input  logic              start,
    output logic              i2c_sclk,
    inout  wire               i2c_sdat,
    output logic              done,
    output logic              ack,
    output logic [2:0]        state_dbg
);

    state_t            state;
    quarter_t          quarter;
    logic [DATA_W-1:0] sreg;
    logic [2:0]        bit_cnt;
    logic [1:0]        byte_cnt;
    logic              nack_seen;
    logic              sda_low;
    logic              tick;
    logic              accept;

    assign accept    = (state == ST_IDLE) && start;
    assign i2c_sdat  = sda_low ? 1'b0 : 1'bz;
    assign state_dbg = state;

    i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .tick  (tick)
    );

    // Outputs are updated on the edge that begins each quarter, so every
    // branch below sets the pin levels for the quarter being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            quarter   <= Q0;
            sreg      <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            nack_seen <= 1'b0;
            i2c_sclk  <= 1'b1;
            sda_low   <= 1'b0;
            done      <= 1'b0;
            ack       <= 1'b0;
        end else begin
            if (tick && state != ST_IDLE) begin
                quarter <= quarter_t'(quarter + 2'd1);
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sreg      <= i2c_data;
                        done      <= 1'b0;
                        ack       <= 1'b0;
                        nack_seen <= 1'b0;
                        bit_cnt   <= '0;
                        byte_cnt  <= '0;
                        quarter   <= Q0;
                        i2c_sclk  <= 1'b1;
                        sda_low   <= 1'b0;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        case (quarter)
                            Q0: ;
                            Q1: sda_low <= 1'b1;
                            Q2: i2c_sclk <= 1'b0;
                            Q3: begin
                                sda_low <= ~sreg[DATA_W-1];
                                state   <= ST_DATA;
                            end
                        endcase
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        case (quarter)
                            Q0: ;
                            Q1: i2c_sclk <= 1'b1;
                            Q2: ;
                            Q3: begin
                                i2c_sclk <= 1'b0;
                                sreg     <= {sreg[DATA_W-2:0], 1'b0};
                                if (bit_cnt == 3'd7) begin
                                    bit_cnt <= '0;
                                    sda_low <= 1'b0;
                                    state   <= ST_ACK;
                                end else begin
                                    bit_cnt <= bit_cnt + 3'd1;
                                    sda_low <= ~sreg[DATA_W-2];
                                end
                            end
                        endcase
                    end
                end
                ST_ACK: begin
                    if (tick) begin
                        case (quarter)
                            Q0: ;
                            Q1: i2c_sclk <= 1'b1;
                            Q2: nack_seen <= nack_seen | i2c_sdat;
                            Q3: begin
                                i2c_sclk <= 1'b0;
                                byte_cnt <= byte_cnt + 2'd1;
                                if (nack_seen || byte_cnt == 2'(NUM_BYTES - 1)) begin
                                    sda_low <= 1'b1;
                                    state   <= ST_STOP;
                                end else begin
                                    sda_low <= ~sreg[DATA_W-1];
                                    state   <= ST_DATA;
                                end
                            end
                        endcase
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        case (quarter)
                            Q0: i2c_sclk <= 1'b1;
                            Q1: sda_low <= 1'b0;
                            Q2: ;
                            Q3: begin
                                done  <= 1'b1;
                                ack   <= ~nack_seen;
                                state <= ST_IDLE;
                            end
                        endcase
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_write_engine.sv
// Randomized bench for i2c_write_engine: slave/protocol monitor on the pins plus a transaction-level reference model.
module tb_i2c_write_engine;
    import i2c_write_engine_pkg::*;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] i2c_data = '0;
    logic        start = 1'b0;
    logic        i2c_sclk;
    logic        done;
    logic        ack;
    logic [2:0]  state_dbg;
    wire         sda_bus;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Slave and bus monitor state
    logic     slave_low = 1'b0;
    logic     prev_scl = 1'b1;
    logic     prev_sda = 1'b1;
    bit       mon_en = 1'b0;
    int       nack_byte = 0;
    int       bitpos = 0;
    int       byte_idx = 0;
    logic [7:0] shreg = '0;
    int       rise_cnt = 0;
    int       start_cnt = 0;
    int       stop_cnt = 0;
    int       viol_cnt = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    pullup (sda_bus);
    assign sda_bus = slave_low ? 1'b0 : 1'bz;

    i2c_write_engine #(.CLK_DIV(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .i2c_data  (i2c_data),
        .start     (start),
        .i2c_sclk  (i2c_sclk),
        .i2c_sdat  (sda_bus),
        .done      (done),
        .ack       (ack),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic scl;
        logic sda;
        scl = i2c_sclk;
        sda = sda_bus;
        if (sda != prev_sda && prev_scl && scl) begin
            if (!sda) start_cnt++;
            else stop_cnt++;
            bitpos = 0;
            byte_idx = 0;
            slave_low = 1'b0;
        end else if (sda != prev_sda && scl && mon_en) begin
            viol_cnt++;
        end
        if (scl && !prev_scl) begin
            rise_cnt++;
            if (bitpos < 8) shreg = {shreg[6:0], sda};
            bitpos++;
        end else if (!scl && prev_scl) begin
            if (bitpos == 8) begin
                rx_q.push_back(shreg);
                slave_low = (byte_idx + 1 != nack_byte);
            end else if (bitpos == 9) begin
                slave_low = 1'b0;
                bitpos = 0;
                byte_idx++;
            end
        end
        prev_scl = scl;
        prev_sda = sda;
    end

    // One write: hold keeps start high so the next request is accepted at once;
    // chained means this write was accepted from a held start.
    task automatic run_txn(input logic [23:0] data, input int nack_b, input int pulse_at,
                           input bit chained, input bit hold);
        int nb, a, lat, rx0, r0, s0, p0, v0, exp_lat;
        bit seen;
        nb = (nack_b == 0) ? NUM_BYTES : nack_b;
        exp_lat = (8 + 36 * nb) * D;
        exp_q.delete();
        for (int i = 0; i < nb; i++) exp_q.push_back(data[23 - 8 * i -: 8]);
        nack_byte = nack_b;
        rx0 = rx_q.size();
        r0 = rise_cnt; s0 = start_cnt; p0 = stop_cnt; v0 = viol_cnt;
        i2c_data = data;
        if (!chained) begin
            @(negedge clk);
            start = 1'b1;
        end
        @(negedge clk);
        start = hold;
        a = cyc;
        check_eq(chained ? "done_one_cycle" : "done_fall", 32'(done), 32'd0);
        seen = 1'b0;
        lat = 0;
        while (!seen && lat < 200 * D) begin
            @(negedge clk);
            lat = cyc - a;
            if (done) seen = 1'b1;
            start = hold ? 1'b1 : ((lat == pulse_at) && !seen);
        end
        check_eq("done_timeout", 32'(seen), 32'd1);
        check_eq("done_latency", 32'(lat), 32'(exp_lat));
        check_eq("ack", 32'(ack), 32'(nack_b == 0));
        check_eq("rx_count", 32'(rx_q.size() - rx0), 32'(nb));
        for (int i = 0; i < nb; i++) begin
            if (rx0 + i < rx_q.size())
                check_eq($sformatf("byte%0d", i), 32'(rx_q[rx0 + i]), 32'(exp_q[i]));
        end
        check_eq("scl_rises", 32'(rise_cnt - r0), 32'(9 * nb + 1));
        check_eq("start_cond", 32'(start_cnt - s0), 32'd1);
        check_eq("stop_cond", 32'(stop_cnt - p0), 32'd1);
        check_eq("sda_while_scl_high", 32'(viol_cnt - v0), 32'd0);
        if (!hold) begin
            repeat ($urandom_range(1, 8)) @(negedge clk);
            check_eq("done_hold", 32'(done), 32'd1);
            check_eq("ack_hold", 32'(ack), 32'(nack_b == 0));
        end
    endtask

    task automatic reset_mid_txn(input logic [23:0] data);
        nack_byte = 0;
        @(negedge clk);
        i2c_data = data;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4 * D + 10) @(negedge clk);
        mon_en = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("rst_sclk", 32'(i2c_sclk), 32'd1);
        check_eq("rst_sda", 32'(sda_bus), 32'd1);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_ack", 32'(ack), 32'd0);
        check_eq("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_eq("init_sclk", 32'(i2c_sclk), 32'd1);
        check_eq("init_sda", 32'(sda_bus), 32'd1);
        check_eq("init_done", 32'(done), 32'd0);
        check_eq("init_ack", 32'(ack), 32'd0);
        check_eq("init_state", 32'(state_dbg), 32'(ST_IDLE));
        reset = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;

        run_txn(24'h3F0C10, 0, -1, 1'b0, 1'b0);
        run_txn(24'h3F0C10, 2, -1, 1'b0, 1'b0);
        run_txn(24'($urandom), 0, 100, 1'b0, 1'b0);
        reset_mid_txn(24'($urandom));
        run_txn(24'($urandom), 0, -1, 1'b0, 1'b0);
        run_txn(24'($urandom), 0, -1, 1'b0, 1'b1);
        run_txn(24'($urandom), 0, -1, 1'b1, 1'b0);

        for (int i = 0; i < 6; i++) begin
            run_txn(24'($urandom), int'($urandom_range(0, 3)),
                    ($urandom_range(0, 1) != 0) ? int'($urandom_range(20, 300)) : -1,
                    1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
